// File: rtl/processor_core_if.sv
// Debug/trace bundle for processor_core: every pipeline register, decoded
// control and hazard signal, driven by the core and observed by a tracer.
interface processor_core_if;
    logic        flag_eq, flag_gt;
    logic [31:0] PCF, instructionF, branchTargetF, immxF, op1F, op2F, branchPCF;
    logic [3:0]  rdF, rs1F, rs2F;
    logic        isStF, isLdF, isBeqF, isBgtF, isRetF, isImmediateF, isWbF, isUbranchF,
                 isCallF, isAddF, isSubF, isCmpF, isMulF, isDivF, isModF, isLslF,
                 isLsrF, isAsrF, isOrF, isAndF, isNotF, isMovF;
    logic        isBranchTakenF;
    logic [31:0] PCE, instructionE, branchTargetE, immxE, op1E, op2E, branchPCE;
    logic [3:0]  rdE, rs1E, rs2E;
    logic        isStE, isLdE, isBeqE, isBgtE, isRetE, isImmediateE, isWbE, isUbranchE,
                 isCallE, isAddE, isSubE, isCmpE, isMulE, isDivE, isModE, isLslE,
                 isLsrE, isAsrE, isOrE, isAndE, isNotE, isMovE;
    logic        isBranchTakenE;
    logic [31:0] aluResult;
    logic        stallF, stallC, track;

    modport master (
        output flag_eq, flag_gt,
        output PCF, instructionF, branchTargetF, immxF, op1F, op2F, branchPCF, rdF, rs1F, rs2F,
        output isStF, isLdF, isBeqF, isBgtF, isRetF, isImmediateF, isWbF, isUbranchF,
               isCallF, isAddF, isSubF, isCmpF, isMulF, isDivF, isModF, isLslF,
               isLsrF, isAsrF, isOrF, isAndF, isNotF, isMovF, isBranchTakenF,
        output PCE, instructionE, branchTargetE, immxE, op1E, op2E, branchPCE, rdE, rs1E, rs2E,
        output isStE, isLdE, isBeqE, isBgtE, isRetE, isImmediateE, isWbE, isUbranchE,
               isCallE, isAddE, isSubE, isCmpE, isMulE, isDivE, isModE, isLslE,
               isLsrE, isAsrE, isOrE, isAndE, isNotE, isMovE, isBranchTakenE,
        output aluResult, stallF, stallC, track
    );

    modport slave (
        input flag_eq, flag_gt,
        input PCF, instructionF, branchTargetF, immxF, op1F, op2F, branchPCF, rdF, rs1F, rs2F,
        input isStF, isLdF, isBeqF, isBgtF, isRetF, isImmediateF, isWbF, isUbranchF,
              isCallF, isAddF, isSubF, isCmpF, isMulF, isDivF, isModF, isLslF,
              isLsrF, isAsrF, isOrF, isAndF, isNotF, isMovF, isBranchTakenF,
        input PCE, instructionE, branchTargetE, immxE, op1E, op2E, branchPCE, rdE, rs1E, rs2E,
        input isStE, isLdE, isBeqE, isBgtE, isRetE, isImmediateE, isWbE, isUbranchE,
              isCallE, isAddE, isSubE, isCmpE, isMulE, isDivE, isModE, isLslE,
              isLsrE, isAsrE, isOrE, isAndE, isNotE, isMovE, isBranchTakenE,
        input aluResult, stallF, stallC, track
    );
endinterface

// File: rtl/processor_core.sv
// Two-stage SimpleRISC core: F fetches/decodes/reads operands, E executes,
// resolves branches, accesses data RAM and writes back. No forwarding: a
// dependent instruction waits one cycle in F; a taken branch flushes F.
module processor_core #(
    parameter string IMEM_FILE  = "program.hex",
    parameter int    DMEM_WORDS = 256
) (
    input  logic clk,
    input  logic reset,
    processor_core_if.master dbg
);
    localparam int AW = $clog2(DMEM_WORDS);

    typedef struct packed {
        logic isSt, isLd, isBeq, isBgt, isRet, isImmediate, isWb, isUbranch, isCall,
              isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr,
              isOr, isAnd, isNot, isMov;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc, instr, branchTarget, immx, op1, op2, branchPC;
        logic [3:0]  rd, rs1, rs2;
        ctrl_t       ctrl;
    } stage_t;

    // Undefined opcodes fall out as all-zero controls, i.e. a nop.
    function automatic ctrl_t decode(input logic [4:0] op, input logic iBit);
        ctrl_t c;
        c = '0;
        c.isAdd = (op == 5'd0);   c.isSub = (op == 5'd1);   c.isMul = (op == 5'd2);
        c.isDiv = (op == 5'd3);   c.isMod = (op == 5'd4);   c.isCmp = (op == 5'd5);
        c.isAnd = (op == 5'd6);   c.isOr  = (op == 5'd7);   c.isNot = (op == 5'd8);
        c.isMov = (op == 5'd9);   c.isLsl = (op == 5'd10);  c.isLsr = (op == 5'd11);
        c.isAsr = (op == 5'd12);  c.isLd  = (op == 5'd14);  c.isSt  = (op == 5'd15);
        c.isBeq = (op == 5'd16);  c.isBgt = (op == 5'd17);  c.isCall = (op == 5'd19);
        c.isRet = (op == 5'd20);
        c.isUbranch   = (op == 5'd18) | c.isCall | c.isRet;
        c.isImmediate = iBit;
        c.isWb = c.isAdd | c.isSub | c.isMul | c.isDiv | c.isMod | c.isAnd | c.isOr |
                 c.isNot | c.isMov | c.isLsl | c.isLsr | c.isAsr | c.isLd | c.isCall;
        return c;
    endfunction

    logic [31:0] imem [256];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [16];

    logic [31:0] pc;
    stage_t      fS, eS;
    logic        track, flagEq, flagGt;
    logic [31:0] instrF, immxF, targetF, op1F, op2F;
    ctrl_t       ctrlF;
    logic        usesA, usesB, stallF, stallC, takenF, takenE;
    logic [3:0]  src1F, src2F, wbDest;
    logic [31:0] aluB, alu, wbData;
    logic [AW-1:0] dAddr;

    assign instrF  = imem[pc[9:2]];
    assign ctrlF   = decode(instrF[31:27], instrF[26]);
    assign targetF = pc + {{3{instrF[26]}}, instrF[26:0], 2'b00};
    assign src1F   = ctrlF.isRet ? 4'd15 : instrF[21:18];
    assign src2F   = ctrlF.isSt ? instrF[25:22] : instrF[17:14];
    assign op1F    = rf[src1F];
    assign op2F    = rf[src2F];

    // Immediate extension selected by the two modifier bits.
    always_comb begin
        immxF = {{16{instrF[15]}}, instrF[15:0]};
        case (instrF[17:16])
            2'b01:   immxF = {16'd0, instrF[15:0]};
            2'b10:   immxF = {instrF[15:0], 16'd0};
            default: immxF = {{16{instrF[15]}}, instrF[15:0]};
        endcase
    end

    // Assemble the F-stage record that E captures.
    always_comb begin
        fS              = '0;
        fS.pc           = pc;
        fS.instr        = instrF;
        fS.branchTarget = targetF;
        fS.immx         = immxF;
        fS.op1          = op1F;
        fS.op2          = op2F;
        fS.branchPC     = ctrlF.isRet ? op1F : targetF;
        fS.rd           = instrF[25:22];
        fS.rs1          = instrF[21:18];
        fS.rs2          = instrF[17:14];
        fS.ctrl         = ctrlF;
    end

    // Which register-file ports the F instruction actually depends on, so
    // unused fields (e.g. the imm bits overlapping rs2) never cause stalls.
    assign usesA = ctrlF.isAdd | ctrlF.isSub | ctrlF.isMul | ctrlF.isDiv | ctrlF.isMod |
                   ctrlF.isCmp | ctrlF.isAnd | ctrlF.isOr | ctrlF.isLsl | ctrlF.isLsr |
                   ctrlF.isAsr | ctrlF.isLd | ctrlF.isSt | ctrlF.isRet;
    assign usesB = ctrlF.isSt | (!ctrlF.isImmediate &
                   (ctrlF.isAdd | ctrlF.isSub | ctrlF.isMul | ctrlF.isDiv | ctrlF.isMod |
                    ctrlF.isCmp | ctrlF.isAnd | ctrlF.isOr | ctrlF.isLsl | ctrlF.isLsr |
                    ctrlF.isAsr | ctrlF.isNot | ctrlF.isMov));

    assign wbDest = eS.ctrl.isCall ? 4'd15 : eS.rd;
    assign stallF = track & eS.ctrl.isWb &
                    ((usesA & (wbDest == src1F)) | (usesB & (wbDest == src2F)));
    assign takenF = ctrlF.isUbranch | (ctrlF.isBeq & flagEq) | (ctrlF.isBgt & flagGt);
    assign takenE = eS.ctrl.isUbranch | (eS.ctrl.isBeq & flagEq) | (eS.ctrl.isBgt & flagGt);
    assign stallC = takenE & track;

    // E-stage ALU; ld/st use it for the address add.
    assign aluB = eS.ctrl.isImmediate ? eS.immx : eS.op2;
    always_comb begin
        alu = '0;
        if (eS.ctrl.isAdd | eS.ctrl.isLd | eS.ctrl.isSt) alu = eS.op1 + aluB;
        else if (eS.ctrl.isSub | eS.ctrl.isCmp)          alu = eS.op1 - aluB;
        else if (eS.ctrl.isMul)                          alu = eS.op1 * aluB;
        else if (eS.ctrl.isDiv)                          alu = (aluB == '0) ? '0 : 32'($signed(eS.op1) / $signed(aluB));
        else if (eS.ctrl.isMod)                          alu = (aluB == '0) ? '0 : 32'($signed(eS.op1) % $signed(aluB));
        else if (eS.ctrl.isAnd)                          alu = eS.op1 & aluB;
        else if (eS.ctrl.isOr)                           alu = eS.op1 | aluB;
        else if (eS.ctrl.isNot)                          alu = ~aluB;
        else if (eS.ctrl.isMov)                          alu = aluB;
        else if (eS.ctrl.isLsl)                          alu = eS.op1 << aluB[4:0];
        else if (eS.ctrl.isLsr)                          alu = eS.op1 >> aluB[4:0];
        else if (eS.ctrl.isAsr)                          alu = 32'($signed(eS.op1) >>> aluB[4:0]);
    end

    assign dAddr  = alu[AW+1:2];
    assign wbData = eS.ctrl.isLd ? dmem[dAddr] : (eS.ctrl.isCall ? eS.pc + 32'd4 : alu);

    // PC and F->E pipeline register; a redirect beats a data stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            eS    <= '0;
            track <= 1'b0;
        end else if (stallC) begin
            pc    <= eS.branchPC;
            eS    <= '0;
            track <= 1'b0;
        end else if (stallF) begin
            eS    <= '0;
            track <= 1'b0;
        end else begin
            pc    <= pc + 32'd4;
            eS    <= fS;
            track <= 1'b1;
        end
    end

    // Register file writeback and flag update at the end of the E cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            flagEq <= 1'b0;
            flagGt <= 1'b0;
        end else if (track) begin
            if (eS.ctrl.isWb) rf[wbDest] <= wbData;
            if (eS.ctrl.isCmp) begin
                flagEq <= (eS.op1 == aluB);
                flagGt <= ($signed(eS.op1) > $signed(aluB));
            end
        end
    end

    // Data RAM keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (track && eS.ctrl.isSt) dmem[dAddr] <= eS.op2;
    end

    assign dbg.flag_eq        = flagEq;
    assign dbg.flag_gt        = flagGt;
    assign dbg.PCF            = fS.pc;
    assign dbg.instructionF   = fS.instr;
    assign dbg.branchTargetF  = fS.branchTarget;
    assign dbg.immxF          = fS.immx;
    assign dbg.op1F           = fS.op1;
    assign dbg.op2F           = fS.op2;
    assign dbg.branchPCF      = fS.branchPC;
    assign dbg.rdF            = fS.rd;
    assign dbg.rs1F           = fS.rs1;
    assign dbg.rs2F           = fS.rs2;
    assign {dbg.isStF, dbg.isLdF, dbg.isBeqF, dbg.isBgtF, dbg.isRetF, dbg.isImmediateF,
            dbg.isWbF, dbg.isUbranchF, dbg.isCallF, dbg.isAddF, dbg.isSubF, dbg.isCmpF,
            dbg.isMulF, dbg.isDivF, dbg.isModF, dbg.isLslF, dbg.isLsrF, dbg.isAsrF,
            dbg.isOrF, dbg.isAndF, dbg.isNotF, dbg.isMovF} = fS.ctrl;
    assign dbg.isBranchTakenF = takenF;
    assign dbg.PCE            = eS.pc;
    assign dbg.instructionE   = eS.instr;
    assign dbg.branchTargetE  = eS.branchTarget;
    assign dbg.immxE          = eS.immx;
    assign dbg.op1E           = eS.op1;
    assign dbg.op2E           = eS.op2;
    assign dbg.branchPCE      = eS.branchPC;
    assign dbg.rdE            = eS.rd;
    assign dbg.rs1E           = eS.rs1;
    assign dbg.rs2E           = eS.rs2;
    assign {dbg.isStE, dbg.isLdE, dbg.isBeqE, dbg.isBgtE, dbg.isRetE, dbg.isImmediateE,
            dbg.isWbE, dbg.isUbranchE, dbg.isCallE, dbg.isAddE, dbg.isSubE, dbg.isCmpE,
            dbg.isMulE, dbg.isDivE, dbg.isModE, dbg.isLslE, dbg.isLsrE, dbg.isAsrE,
            dbg.isOrE, dbg.isAndE, dbg.isNotE, dbg.isMovE} = eS.ctrl;
    assign dbg.isBranchTakenE = takenE;
    assign dbg.aluResult      = alu;
    assign dbg.stallF         = stallF;
    assign dbg.stallC         = stallC;
    assign dbg.track          = track;
endmodule

// File: tb/tb_processor_core.sv
// Program-driven bench: each scenario loads a small program into the ROM,
// queues the register writebacks it must produce, and checks them in order
// as they retire, plus pipeline/hazard observations along the way.
module tb_processor_core;
    logic clk;
    logic reset;
    int   checks, errors;

    typedef struct { logic [3:0] dest; logic [31:0] value; } wb_t;
    wb_t  sbQ[$];
    logic pendValid;
    logic [3:0] pendDest;
    int   wp;

    localparam logic [31:0] NOP = {5'd13, 27'd0};

    processor_core_if dbg();
    processor_core #(.IMEM_FILE(""), .DMEM_WORDS(256)) dut (.clk(clk), .reset(reset), .dbg(dbg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] encR(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'd0};
    endfunction
    function automatic logic [31:0] encI(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1, input logic [1:0] m, input logic [15:0] imm);
        return {op, 1'b1, rd, rs1, m, imm};
    endfunction
    function automatic logic [31:0] encB(input logic [4:0] op, input logic [26:0] off);
        return {op, off};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 256; i++) dut.imem[i] = NOP;
        wp = 0;
    endtask
    task automatic put(input logic [31:0] w);
        dut.imem[wp] = w;
        wp++;
    endtask
    task automatic expWb(input logic [3:0] d, input logic [31:0] v);
        wb_t e;
        e.dest = d; e.value = v;
        sbQ.push_back(e);
    endtask
    task automatic beginProgram();
        reset = 1'b0;
        pendValid = 1'b0;
        sbQ.delete();
        clearRom();
    endtask
    task automatic releaseReset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Advance one cycle and retire the writeback recorded last cycle against the queue.
    task automatic step();
        wb_t e;
        @(negedge clk);
        if (pendValid) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL wb_extra: r%0d written with %h, required no write", pendDest, dut.rf[pendDest]);
            end else begin
                e = sbQ.pop_front();
                if (pendDest !== e.dest || dut.rf[e.dest] !== e.value) begin
                    errors++;
                    $display("FAIL wb_r%0d: got dest r%0d value %h, required r%0d = %h", e.dest, pendDest, dut.rf[e.dest], e.dest, e.value);
                end
            end
        end
        pendValid = dbg.track && dbg.isWbE;
        pendDest  = dbg.isCallE ? 4'd15 : dbg.rdE;
    endtask

    task automatic drainCheck(input string name);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_wb: %0d writebacks outstanding, required 0", name, sbQ.size());
        end
    endtask

    task automatic test_reset();
        beginProgram();
        put(encI(5'd9, 4'd1, 4'd0, 2'b00, 16'd42));
        expWb(4'd1, 32'd42);
        #1;
        checks++;
        if (dbg.PCF !== 32'd0 || dbg.track !== 1'b0 || dbg.aluResult !== 32'd0) begin
            errors++; $display("FAIL reset_state: PCF=%h track=%b alu=%h, required 0/0/0", dbg.PCF, dbg.track, dbg.aluResult);
        end
        checks++;
        if (dbg.flag_eq !== 1'b0 || dbg.flag_gt !== 1'b0 || dbg.stallF !== 1'b0 || dbg.stallC !== 1'b0) begin
            errors++; $display("FAIL reset_flags: eq=%b gt=%b stallF=%b stallC=%b, required 0", dbg.flag_eq, dbg.flag_gt, dbg.stallF, dbg.stallC);
        end
        checks++;
        if (dbg.instructionF !== encI(5'd9, 4'd1, 4'd0, 2'b00, 16'd42)) begin
            errors++; $display("FAIL reset_fetch: instructionF=%h, required ROM[0]", dbg.instructionF);
        end
        releaseReset();
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (dbg.PCF !== 32'(4 * i) || dbg.track !== 1'b1) begin
                errors++; $display("FAIL reset_seq%0d: PCF=%h track=%b, required %h/1", i, dbg.PCF, dbg.track, 32'(4 * i));
            end
        end
        drainCheck("reset");
    endtask

    task automatic test_data_hazard();
        int nStall;
        beginProgram();
        put(encI(5'd9, 4'd1, 4'd0, 2'b00, 16'd5));
        put(encI(5'd9, 4'd2, 4'd0, 2'b00, 16'd7));
        put(encR(5'd0, 4'd3, 4'd1, 4'd2));
        put(encB(5'd18, 27'd0));
        expWb(4'd1, 32'd5); expWb(4'd2, 32'd7); expWb(4'd3, 32'd12);
        releaseReset();
        nStall = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dbg.stallF) begin
                nStall++;
                checks++;
                if (dbg.PCF !== 32'd8 || dbg.rdE !== 4'd2) begin
                    errors++; $display("FAIL hazard_where: stall at PCF=%h rdE=%0d, required PCF=8 rdE=2", dbg.PCF, dbg.rdE);
                end
            end
        end
        checks++;
        if (nStall !== 1) begin
            errors++; $display("FAIL hazard_count: %0d stall cycles, required 1", nStall);
        end
        drainCheck("hazard");
    endtask

    task automatic test_immediates_alu();
        beginProgram();
        put(encI(5'd9, 4'd1, 4'd0, 2'b00, 16'hFFFD));       expWb(4'd1, 32'hFFFFFFFD);
        put(encI(5'd9, 4'd2, 4'd0, 2'b10, 16'h1234));       expWb(4'd2, 32'h12340000);
        put(encI(5'd9, 4'd3, 4'd0, 2'b01, 16'hFFFD));       expWb(4'd3, 32'h0000FFFD);
        put(encI(5'd10, 4'd4, 4'd3, 2'b00, 16'd4));         expWb(4'd4, 32'h000FFFD0);
        put(encR(5'd1, 4'd5, 4'd2, 4'd1));                  expWb(4'd5, 32'h12340003);
        put(encI(5'd12, 4'd6, 4'd1, 2'b00, 16'd1));         expWb(4'd6, 32'hFFFFFFFE);
        put(encI(5'd11, 4'd7, 4'd1, 2'b00, 16'd28));        expWb(4'd7, 32'h0000000F);
        put(encR(5'd2, 4'd8, 4'd1, 4'd1));                  expWb(4'd8, 32'd9);
        put(encI(5'd9, 4'd10, 4'd0, 2'b00, 16'd2));         expWb(4'd10, 32'd2);
        put(encR(5'd3, 4'd9, 4'd2, 4'd10));                 expWb(4'd9, 32'h091A0000);
        put(encR(5'd4, 4'd11, 4'd1, 4'd10));                expWb(4'd11, 32'hFFFFFFFF);
        put(encR(5'd3, 4'd12, 4'd1, 4'd0));                 expWb(4'd12, 32'd0);
        put(encR(5'd7, 4'd13, 4'd2, 4'd3));                 expWb(4'd13, 32'h1234FFFD);
        put(encR(5'd6, 4'd14, 4'd1, 4'd3));                 expWb(4'd14, 32'h0000FFFD);
        put(encR(5'd8, 4'd15, 4'd0, 4'd2));                 expWb(4'd15, 32'hEDCBFFFF);
        put(encR(5'd5, 4'd0, 4'd1, 4'd10));
        put(encB(5'd18, 27'd0));
        releaseReset();
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (dbg.flag_eq !== 1'b0 || dbg.flag_gt !== 1'b0) begin
            errors++; $display("FAIL cmp_signed: eq=%b gt=%b, required 0/0 for -3 vs 2", dbg.flag_eq, dbg.flag_gt);
        end
        drainCheck("alu");
    endtask

    task automatic test_branch();
        logic seen, chkNext, seenBgt;
        beginProgram();
        put(encI(5'd9, 4'd1, 4'd0, 2'b00, 16'd9));
        put(encR(5'd5, 4'd0, 4'd1, 4'd1));
        put(encB(5'd16, 27'd3));
        put(encI(5'd9, 4'd2, 4'd0, 2'b00, 16'd1));
        put(encI(5'd9, 4'd3, 4'd0, 2'b00, 16'd1));
        put(encI(5'd9, 4'd4, 4'd0, 2'b00, 16'd4));
        put(encB(5'd17, 27'd2));
        put(encI(5'd9, 4'd5, 4'd0, 2'b00, 16'd5));
        put(encB(5'd18, 27'd0));
        expWb(4'd1, 32'd9); expWb(4'd4, 32'd4); expWb(4'd5, 32'd5);
        releaseReset();
        seen = 1'b0; chkNext = 1'b0; seenBgt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (chkNext) begin
                chkNext = 1'b0;
                checks++;
                if (dbg.PCF !== 32'd20 || dbg.track !== 1'b0) begin
                    errors++; $display("FAIL beq_redirect: PCF=%h track=%b, required 00000014/0", dbg.PCF, dbg.track);
                end
            end
            if (dbg.isBeqE && dbg.track) begin
                seen = 1'b1; chkNext = 1'b1;
                checks++;
                if (dbg.flag_eq !== 1'b1 || dbg.stallC !== 1'b1 || dbg.branchPCE !== 32'd20) begin
                    errors++; $display("FAIL beq_taken: eq=%b stallC=%b branchPCE=%h, required 1/1/00000014", dbg.flag_eq, dbg.stallC, dbg.branchPCE);
                end
            end
            if (dbg.isBgtE && dbg.track) begin
                seenBgt = 1'b1;
                checks++;
                if (dbg.isBranchTakenE !== 1'b0 || dbg.stallC !== 1'b0) begin
                    errors++; $display("FAIL bgt_not_taken: taken=%b stallC=%b, required 0/0", dbg.isBranchTakenE, dbg.stallC);
                end
            end
        end
        checks++;
        if (!seen || !seenBgt) begin
            errors++; $display("FAIL branch_timeout: beq seen=%b bgt seen=%b, required 1/1", seen, seenBgt);
        end
        drainCheck("branch");
    endtask

    task automatic test_load_store();
        beginProgram();
        dut.dmem[2] = 32'hDEADBEEF;
        put(encI(5'd9, 4'd1, 4'd0, 2'b01, 16'h55AA));
        put(encI(5'd15, 4'd1, 4'd0, 2'b00, 16'd8));
        put(encI(5'd14, 4'd4, 4'd0, 2'b00, 16'd8));
        put(encB(5'd18, 27'd0));
        expWb(4'd1, 32'h000055AA); expWb(4'd4, 32'h000055AA);
        releaseReset();
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (dut.dmem[2] !== 32'h000055AA) begin
            errors++; $display("FAIL store_mem: dmem[2]=%h, required 000055aa", dut.dmem[2]);
        end
        drainCheck("ldst");
    endtask

    task automatic test_call_ret();
        logic seenRet, chkNext;
        beginProgram();
        put(encI(5'd9, 4'd5, 4'd0, 2'b00, 16'd99));
        put(encI(5'd9, 4'd1, 4'd0, 2'b00, 16'd11));
        put(encB(5'd19, 27'd4));
        put(encR(5'd3, 4'd5, 4'd1, 4'd0));
        put(encB(5'd18, 27'd0));
        put(NOP);
        put(encB(5'd20, 27'd0));
        expWb(4'd5, 32'd99); expWb(4'd1, 32'd11); expWb(4'd15, 32'd12); expWb(4'd5, 32'd0);
        releaseReset();
        seenRet = 1'b0; chkNext = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (chkNext) begin
                chkNext = 1'b0;
                checks++;
                if (dbg.PCF !== 32'd12) begin
                    errors++; $display("FAIL ret_resume: PCF=%h, required 0000000c", dbg.PCF);
                end
            end
            if (dbg.isRetE && dbg.track) begin
                seenRet = 1'b1; chkNext = 1'b1;
                checks++;
                if (dbg.stallC !== 1'b1 || dbg.branchPCE !== 32'd12) begin
                    errors++; $display("FAIL ret_taken: stallC=%b branchPCE=%h, required 1/0000000c", dbg.stallC, dbg.branchPCE);
                end
            end
        end
        checks++;
        if (!seenRet) begin
            errors++; $display("FAIL ret_timeout: ret never reached E");
        end
        drainCheck("call");
    endtask

    task automatic test_back_to_back();
        logic seenBgt;
        beginProgram();
        put(encI(5'd9, 4'd1, 4'd0, 2'b00, 16'd5));
        put(encI(5'd9, 4'd2, 4'd0, 2'b00, 16'd3));
        put(encR(5'd5, 4'd0, 4'd1, 4'd2));
        put(encB(5'd17, 27'd2));
        put(encI(5'd9, 4'd6, 4'd0, 2'b00, 16'd1));
        put(encI(5'd9, 4'd7, 4'd0, 2'b00, 16'd7));
        put(encB(5'd18, 27'd0));
        expWb(4'd1, 32'd5); expWb(4'd2, 32'd3); expWb(4'd7, 32'd7);
        releaseReset();
        seenBgt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (dbg.isCmpE && dbg.track) begin
                checks++;
                if (dbg.stallF !== 1'b0 || dbg.PCF !== 32'd12) begin
                    errors++; $display("FAIL cmp_bgt_nostall: stallF=%b PCF=%h, required 0/0000000c", dbg.stallF, dbg.PCF);
                end
            end
            if (dbg.isBgtE && dbg.track) begin
                seenBgt = 1'b1;
                checks++;
                if (dbg.flag_gt !== 1'b1 || dbg.stallC !== 1'b1 || dbg.branchPCE !== 32'd20) begin
                    errors++; $display("FAIL bgt_taken: gt=%b stallC=%b branchPCE=%h, required 1/1/00000014", dbg.flag_gt, dbg.stallC, dbg.branchPCE);
                end
            end
        end
        checks++;
        if (!seenBgt) begin
            errors++; $display("FAIL bgt_timeout: bgt never reached E");
        end
        drainCheck("b2b");
        // Asynchronous reset in the middle of a cycle clears state at once.
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dbg.PCF !== 32'd0 || dbg.track !== 1'b0 || dut.rf[7] !== 32'd0 || dbg.flag_gt !== 1'b0) begin
            errors++; $display("FAIL async_reset: PCF=%h track=%b r7=%h gt=%b, required 0/0/0/0", dbg.PCF, dbg.track, dut.rf[7], dbg.flag_gt);
        end
        pendValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        pendValid = 1'b0;
        pendDest = '0;
        test_reset();
        test_data_hazard();
        test_immediates_alu();
        test_branch();
        test_load_store();
        test_call_ret();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
